refresh_sched: RTL and testbench
================================

REFRESH_SCHED -- requirements
Module: refresh_sched

Interface
REQ-001 The interface SHALL be one clock, sys_clk; reset is synchronous and active-high (port reset), sampled only on the rising edge of sys_clk.
REQ-002 Ports SHALL be:
- sys_clk  in  1  sole clock
- reset  in  1  synchronous active-high reset
- refen  in  1  refresh timer enable
- refdiv  in  10  interval reload value; tick period = refdiv+1 cycles; 0 = timer stopped
- refack  in  1  arbiter grant of the refresh slot (level)
- refdone  in  1  memory controller pulse: refresh cycle complete
- refreq  out  1  refresh bus request to the arbiter (registered)
- refurg  out  1  urgent flag, pending count >= 4 (registered)
- pend  out  3  pending refresh count
- refovf  out  1  sticky: tick lost while pending count saturated
- refto  out  1  sticky: refdone timeout

Function
REQ-003 The block SHALL hold a 10-bit down counter cnt; while refen=1 and refdiv!=0, cnt decrements each cycle, and when cnt=0 it reloads refdiv and generates a one-cycle tick.
REQ-004 While refen=0 or refdiv=0, cnt SHALL load refdiv every cycle and generate no tick; pending refreshes are still served.
REQ-005 A write to refdiv SHALL take effect at the next reload; the count in progress is not truncated.
REQ-006 pend SHALL be a 3-bit counter: +1 on tick, -1 on refresh completion, unchanged when both occur in the same cycle.
REQ-007 On a tick with pend=7 and no completion in that cycle, pend SHALL stay 7 and refovf SHALL be set.
REQ-008 FSM states SHALL be IDLE, REQ and ACTIVE.
- IDLE -> REQ when registered pend != 0.
- REQ -> ACTIVE when refack=1.
- ACTIVE -> IDLE when refdone=1, or when the timeout fires.
REQ-009 refreq SHALL be 1 exactly while the state is REQ; it drops in the cycle after refack is sampled.
REQ-010 Latency: for a tick in cycle n with pend=0 and state IDLE, pend=1 SHALL be visible in cycle n+1 and refreq=1 in cycle n+2.
REQ-011 In ACTIVE, a 4-bit watchdog SHALL count from 0 on entry; if refdone has not arrived when the watchdog reaches 15, the FSM returns to IDLE, refto is set, and pend is decremented as for a completion.
REQ-012 refdone SHALL be ignored outside ACTIVE.
REQ-013 refack SHALL be ignored in IDLE and ACTIVE; refack in the same cycle as the IDLE->REQ transition has no effect.
REQ-014 After ACTIVE->IDLE, if pend is still nonzero the FSM SHALL re-enter REQ on the next cycle; there is exactly one IDLE cycle between back-to-back refreshes.
REQ-015 refurg SHALL be registered as (pend >= 4), updating one cycle after pend.
REQ-016 refovf and refto SHALL be sticky and cleared only by reset.

Reset
REQ-017 When reset=1 at a clock edge, the block SHALL set state=IDLE, cnt=refdiv, pend=0, watchdog=0, refreq=0, refurg=0, refovf=0 and refto=0.
REQ-018 A reset in any state, including ACTIVE with refack held, SHALL abandon the refresh in progress; refreq is 0 in the first cycle after reset.

Verification
REQ-019 Setup refdiv=9, refen=1, refack tied 1, refdone pulsed 2 cycles after each grant -> tick every 10 cycles; refreq rises 2 cycles after each tick; pend stays within 0..1; refovf=0.
REQ-020 Setup refdiv=3, refack=0 for 40 cycles -> pend rises to 7; refurg=1 from one cycle after pend=4; refovf=1 on the 8th tick; pend remains 7.
REQ-021 Setup pend=7, then grant with refdone in the same cycle as a tick -> pend stays 7, refovf unchanged; the next completion without a tick gives pend=6.
REQ-022 Setup grant, refdone never asserted -> ACTIVE for 16 cycles, then IDLE; refto=1; pend decremented by 1; refreq re-asserts if pend>0.
REQ-023 Setup refen=0 with pend=2 -> no new ticks; two refreshes are served, each separated by one IDLE cycle; pend ends at 0 and refreq ends at 0.
REQ-024 Setup reset=1 for one cycle during ACTIVE with pend=3 -> next cycle: pend=0, refreq=0, refurg=0, refto=0, refovf=0, and the first tick occurs refdiv+1 cycles after reset is released.

Source files
------------

// File: rtl/refresh_sched.sv
//------------------------------------------------------------------------------
// Module      : refresh_sched
// Description : DRAM refresh scheduler with an interval timer, a pending
//               refresh counter and a request/grant/done handshake FSM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module refresh_sched (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       refen,
    input  logic [9:0] refdiv,
    input  logic       refack,
    input  logic       refdone,
    output logic       refreq,
    output logic       refurg,
    output logic [2:0] pend,
    output logic       refovf,
    output logic       refto
);

    localparam logic [3:0] c_WD_MAX   = 4'hF;
    localparam logic [2:0] c_PEND_MAX = 3'd7;
    localparam logic [2:0] c_URG_LVL  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t     r_state;
    logic [9:0] r_cnt;
    logic [3:0] r_wd;

    logic w_run;
    logic w_tick;
    logic w_done;
    logic w_timeout;

    assign w_run     = refen && (refdiv != 10'd0);
    assign w_tick    = w_run && (r_cnt == 10'd0);
    // A watchdog expiry retires the refresh exactly like a completion.
    assign w_done    = (r_state == ST_ACTIVE) && (refdone || (r_wd == c_WD_MAX));
    assign w_timeout = (r_state == ST_ACTIVE) && !refdone && (r_wd == c_WD_MAX);

    // Interval timer; reloading every cycle while stopped keeps refdiv live.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_cnt <= refdiv;
        end else if (!w_run || (r_cnt == 10'd0)) begin
            r_cnt <= refdiv;
        end else begin
            r_cnt <= r_cnt - 10'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pend   <= 3'd0;
            refovf <= 1'b0;
            refto  <= 1'b0;
            refurg <= 1'b0;
        end else begin
            if (w_tick && !w_done) begin
                if (pend == c_PEND_MAX) begin
                    refovf <= 1'b1;
                end else begin
                    pend <= pend + 3'd1;
                end
            end else if (w_done && !w_tick && (pend != 3'd0)) begin
                pend <= pend - 3'd1;
            end
            if (w_timeout) begin
                refto <= 1'b1;
            end
            refurg <= (pend >= c_URG_LVL);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_wd    <= 4'd0;
            refreq  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pend != 3'd0) begin
                        r_state <= ST_REQ;
                        refreq  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (refack) begin
                        r_state <= ST_ACTIVE;
                        r_wd    <= 4'd0;
                        refreq  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    refreq  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_refresh_sched.sv
//------------------------------------------------------------------------------
// Module      : tb_refresh_sched
// Description : Directed self-checking bench for refresh_sched.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_refresh_sched;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       refen   = 1'b1;
    logic [9:0] refdiv  = 10'd9;
    logic       refack  = 1'b0;
    logic       refdone = 1'b0;
    logic       refreq;
    logic       refurg;
    logic [2:0] pend;
    logic       refovf;
    logic       refto;

    int n_checks = 0;
    int n_errors = 0;

    refresh_sched u_dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .refen   (refen),
        .refdiv  (refdiv),
        .refack  (refack),
        .refdone (refdone),
        .refreq  (refreq),
        .refurg  (refurg),
        .pend    (pend),
        .refovf  (refovf),
        .refto   (refto)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        // Reset with refdiv=9: edge 0 is the reset edge.
        step(1);
        check("rst_pend",   32'(pend),   0);
        check("rst_refreq", 32'(refreq), 0);
        check("rst_refurg", 32'(refurg), 0);
        check("rst_refovf", 32'(refovf), 0);
        check("rst_refto",  32'(refto),  0);
        reset = 1'b0;

        // Tick in cycle after edge 9: pend=1 at edge 10, refreq at edge 11.
        step(9);
        check("lat_pend0",   32'(pend),   0);
        step(1);
        check("lat_pend1",   32'(pend),   1);
        check("lat_req0",    32'(refreq), 0);
        step(1);
        check("lat_req1",    32'(refreq), 1);

        // Grant then done two cycles later.
        refack = 1'b1;
        step(1);
        check("grant_req_drop", 32'(refreq), 0);
        refack  = 1'b0;
        refdone = 1'b1;
        step(1);
        refdone = 1'b0;
        check("done_pend",   32'(pend),   0);
        step(1);
        check("idle_req",    32'(refreq), 0);
        step(6);
        check("tick2_pend",  32'(pend),   1);
        check("tick2_req0",  32'(refreq), 0);
        step(1);
        check("tick2_req1",  32'(refreq), 1);

        // Hold off grant until the next tick: pend=2 at edge 30.
        step(9);
        check("pend2",       32'(pend),   2);
        check("pend2_req",   32'(refreq), 1);

        // Watchdog timeout: no refdone, refack left high throughout.
        refen  = 1'b0;
        refack = 1'b1;
        step(16);
        check("wd_active_req", 32'(refreq), 0);
        check("wd_pre_refto",  32'(refto),  0);
        check("wd_pre_pend",   32'(pend),   2);
        step(1);
        check("wd_refto",      32'(refto),  1);
        check("wd_pend",       32'(pend),   1);
        check("wd_idle_req",   32'(refreq), 0);
        step(1);
        check("wd_rereq",      32'(refreq), 1);
        refack = 1'b0;

        // Saturation with refdiv=3 and no grants.
        reset  = 1'b1;
        refen  = 1'b1;
        refdiv = 10'd3;
        step(1);
        reset = 1'b0;
        check("rst2_refto",  32'(refto),  0);
        check("rst2_pend",   32'(pend),   0);
        step(16);
        check("sat_pend4",   32'(pend),   4);
        check("sat_urg0",    32'(refurg), 0);
        step(1);
        check("sat_urg1",    32'(refurg), 1);
        check("sat_req",     32'(refreq), 1);
        step(11);
        check("sat_pend7",   32'(pend),   7);
        check("sat_ovf0",    32'(refovf), 0);
        step(3);
        check("sat_ovf_pre", 32'(refovf), 0);
        step(1);
        check("sat_ovf1",    32'(refovf), 1);
        check("sat_pend7b",  32'(pend),   7);

        // Completion coinciding with a tick (cycle after edge R35).
        step(1);
        refack = 1'b1;
        step(1);
        refack = 1'b0;
        step(1);
        refdone = 1'b1;
        step(1);
        refdone = 1'b0;
        check("coinc_pend",  32'(pend),   7);
        check("coinc_ovf",   32'(refovf), 1);
        step(1);
        refack = 1'b1;
        step(1);
        refack  = 1'b0;
        refdone = 1'b1;
        step(1);
        refdone = 1'b0;
        refen   = 1'b0;
        check("solo_done_pend", 32'(pend), 6);

        // Reset during ACTIVE with refack held.
        step(1);
        refack = 1'b1;
        step(1);
        reset  = 1'b1;
        refdiv = 10'd9;
        refen  = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst3_pend",   32'(pend),   0);
        check("rst3_refreq", 32'(refreq), 0);
        check("rst3_refurg", 32'(refurg), 0);
        check("rst3_refovf", 32'(refovf), 0);
        check("rst3_refto",  32'(refto),  0);
        step(9);
        check("rst3_notick", 32'(pend),   0);
        check("rst3_idle",   32'(refreq), 0);
        step(1);
        check("rst3_tick",   32'(pend),   1);
        refack = 1'b0;
        step(1);
        check("rst3_req",    32'(refreq), 1);

        // Timer stopped with pend=2: serve both with one IDLE cycle between.
        step(9);
        check("stop_pend2",  32'(pend),   2);
        refen  = 1'b0;
        refack = 1'b1;
        step(1);
        refdone = 1'b1;
        step(1);
        refdone = 1'b0;
        check("stop_pend1",  32'(pend),   1);
        check("stop_gap",    32'(refreq), 0);
        step(1);
        check("stop_rereq",  32'(refreq), 1);
        step(1);
        refdone = 1'b1;
        step(1);
        refdone = 1'b0;
        check("stop_pend0",  32'(pend),   0);
        step(12);
        check("stop_final_pend", 32'(pend),   0);
        check("stop_final_req",  32'(refreq), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
